// File: rtl/uwu_pkg.sv
// Types and helpers shared by the uwu UART receiver and transmitter.
package uwu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Integer divide rounded to nearest, so the bit period error stays within half a clock.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uwu_sync.sv
// N-flop synchroniser for asynchronous inputs; flops reset to 1 (idle line level).
module uwu_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [N-1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= '1;
    else        ff_q <= {ff_q[N-2:0], async_i};
  end

  assign sync_o = ff_q[N-1];

endmodule

// File: rtl/uwu_uart_rx.sv
// 8N1 UART receiver with valid/ready output, frame-error and overrun pulses.
// Define UWU_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote (adds one cycle of latency).
//
// state     | meaning
// IDLE      | line high, waiting for a start edge
// START     | confirming the start bit at mid-bit
// DATA      | sampling 8 data bits, LSB first
// STOP      | sampling the stop bit, delivering the byte
// WAIT_IDLE | framing error seen, waiting for the line to return high
module uwu_uart_rx
  import uwu_pkg::*;
#(
  parameter int CLK_FREQ = 6000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam logic [CW-1:0] BIT_END = CW'(CPB - 1);
`ifdef UWU_RX_MAJORITY_EN
  localparam logic [CW-1:0] START_END = CW'(HALF);
`else
  localparam logic [CW-1:0] START_END = CW'(HALF - 1);
`endif

  logic            rxs;
  logic            bit_s;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  uwu_sync #(.N(2)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (rx),
    .sync_o  (rxs)
  );

`ifdef UWU_RX_MAJORITY_EN
  // Two previous samples; the vote at a decision point covers counts end-2..end.
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= 2'b11;
    else        hist_q <= {hist_q[0], rxs};
  end

  assign bit_s = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
  assign bit_s = rxs;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (valid_q && ready) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d   = START;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (cnt_q == START_END) begin
          cnt_d   = '0;
          state_d = bit_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d     = '0;
          shift_d   = {bit_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (bit_s) begin
            state_d = IDLE;
            // A byte arriving in the accept cycle replaces the one being consumed.
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uwu_uart_rx.sv
// Directed bench for uwu_uart_rx: cycle-exact frames, glitch, break, overrun and reset cases.
module tb_uwu_uart_rx;
  import uwu_pkg::*;

  localparam int CPB = 52;
`ifdef UWU_RX_MAJORITY_EN
  localparam int VLAT = 498;
`else
  localparam int VLAT = 497;
`endif

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  int n_cmp;
  int n_err;

  int         v_first;
  int         v_cnt;
  logic [7:0] v_data;
  int         fe_cnt;
  int         fe_cyc;
  int         ov_cnt;
  int         ov_cyc;
  logic [2:0] st28;
  logic [2:0] st30;

  uwu_uart_rx #(
    .CLK_FREQ (6000000),
    .BAUD     (115200)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle t starts just after an edge: outputs of cycle t are recorded, then rx is set for it.
  // low_len > 0 replaces the frame by a plain low pulse of that many cycles.
  task automatic run_frame(input logic [7:0] b, input logic stopv, input logic tail,
                           input bit glitch, input int low_len, input int len);
    v_first = -1;
    v_cnt   = 0;
    v_data  = 8'h00;
    fe_cnt  = 0;
    fe_cyc  = -1;
    ov_cnt  = 0;
    ov_cyc  = -1;
    st28    = 3'd7;
    st30    = 3'd7;
    for (int t = 0; t < len; t++) begin
      int   idx;
      logic bv;
      if (valid) begin
        if (v_first < 0) begin
          v_first = t;
          v_data  = data;
        end
        v_cnt++;
      end
      if (frame_err) begin
        fe_cnt++;
        fe_cyc = t;
      end
      if (overrun) begin
        ov_cnt++;
        ov_cyc = t;
      end
      if (t == 28) st28 = dut.state_q;
      if (t == 30) st30 = dut.state_q;
      idx = t / CPB;
      if (low_len > 0)     bv = (t >= low_len);
      else if (idx == 0)   bv = 1'b0;
      else if (idx <= 8)   bv = b[idx-1];
      else if (idx == 9)   bv = stopv;
      else                 bv = tail;
      if (glitch && (t % CPB) == 26) bv = 1'b0;
      rx = bv;
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    rx    = 1'b1;
    ready = 1'b1;
    repeat (3) tick();
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    tick();

    run_frame(8'h55, 1'b1, 1'b1, 1'b0, 0, 520);
    chk("b55_data", 32'(v_data), 32'h55);
    chk("b55_valid_cyc", 32'(v_first), 32'(VLAT));
    chk("b55_valid_cnt", 32'(v_cnt), 32'd1);
    chk("b55_frame_err", 32'(fe_cnt), 32'd0);
    chk("b55_overrun", 32'(ov_cnt), 32'd0);

    run_frame(8'h72, 1'b1, 1'b1, 1'b0, 0, 520);
    chk("b72_data", 32'(v_data), 32'h72);
    chk("b72_valid_cyc", 32'(v_first), 32'(VLAT));
    chk("b72_valid_cnt", 32'(v_cnt), 32'd1);
    chk("b72_frame_err", 32'(fe_cnt), 32'd0);
    chk("b72_overrun", 32'(ov_cnt), 32'd0);

    run_frame(8'h00, 1'b1, 1'b1, 1'b0, 10, 120);
    chk("glitch_state28", 32'(st28), 32'(START));
    chk("glitch_state30", 32'(st30), 32'(IDLE));
    chk("glitch_valid_cnt", 32'(v_cnt), 32'd0);
    chk("glitch_frame_err", 32'(fe_cnt), 32'd0);

    run_frame(8'hA3, 1'b0, 1'b0, 1'b0, 0, 468 + 1000);
    chk("brk_frame_err_cnt", 32'(fe_cnt), 32'd1);
    chk("brk_frame_err_cyc", 32'(fe_cyc), 32'(VLAT));
    chk("brk_valid_cnt", 32'(v_cnt), 32'd0);
    chk("brk_state", 32'(dut.state_q), 32'(WAIT_IDLE));
    rx = 1'b1;
    repeat (20) tick();
    run_frame(8'h41, 1'b1, 1'b1, 1'b0, 0, 520);
    chk("b41_data", 32'(v_data), 32'h41);
    chk("b41_valid_cyc", 32'(v_first), 32'(VLAT));
    chk("b41_frame_err", 32'(fe_cnt), 32'd0);

    ready = 1'b0;
    run_frame(8'h11, 1'b1, 1'b1, 1'b0, 0, 520);
    chk("b11_data", 32'(v_data), 32'h11);
    chk("b11_valid_cyc", 32'(v_first), 32'(VLAT));
    run_frame(8'h22, 1'b1, 1'b1, 1'b0, 0, 520);
    chk("ovr_cnt", 32'(ov_cnt), 32'd1);
    chk("ovr_cyc", 32'(ov_cyc), 32'(VLAT));
    chk("ovr_valid_cnt", 32'(v_cnt), 32'd520);
    chk("ovr_data_held", 32'(data), 32'h11);
    ready = 1'b1;
    tick();
    chk("ready_drop", 32'(valid), 32'h0);
    chk("ready_data_kept", 32'(data), 32'h11);

    run_frame(8'hFF, 1'b1, 1'b1, 1'b0, 0, 28 + 4 * CPB + 10);
    chk("abort_valid_cnt", 32'(v_cnt), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_data", 32'(data), 32'h00);
    chk("abort_state", 32'(dut.state_q), 32'(IDLE));
    rx = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_frame(8'h0F, 1'b1, 1'b1, 1'b0, 0, 520);
    chk("b0f_data", 32'(v_data), 32'h0F);
    chk("b0f_valid_cyc", 32'(v_first), 32'(VLAT));
    chk("b0f_valid_cnt", 32'(v_cnt), 32'd1);

`ifdef UWU_RX_MAJORITY_EN
    run_frame(8'h5A, 1'b1, 1'b1, 1'b1, 0, 520);
`else
    run_frame(8'h5A, 1'b1, 1'b1, 1'b0, 0, 520);
`endif
    chk("b5a_data", 32'(v_data), 32'h5A);
    chk("b5a_valid_cyc", 32'(v_first), 32'(VLAT));
    chk("b5a_frame_err", 32'(fe_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uwu_uart_rx.md
# uwu_uart_rx

UART receiver that sits directly upstream of the uwuifier text transform, turning the asynchronous `rx` pin into a stream of bytes with a valid/ready handshake. It synchronises the pin, validates the start bit, samples 8N1 frames at mid-bit and holds each received byte until the downstream transform accepts it. Framing errors and overruns are flagged as single-cycle pulses.

## Interface
Parameters:
- `CLK_FREQ`, 6000000, system clock frequency in Hz
- `BAUD`, 115200, line rate in bit/s; `CPB` = round(CLK_FREQ/BAUD) = 52, `HALF` = CPB/2 = 26

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rx`  in  1  serial line, idle high, asynchronous to `clk`
- `data`  out  8  received byte, stable while `valid` is high
- `valid`  out  1  `data` holds an unaccepted byte
- `ready`  in  1  downstream accepts `data` when `valid && ready`
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `overrun`  out  1  one-cycle pulse: byte completed while `valid` was still high; new byte dropped

## Operation
- Reset values: `data`=0x00, `valid`=0, `frame_err`=0, `overrun`=0, state IDLE, synchroniser flops=1 (idle line).
- `rx` passes through a 2-flop synchroniser. All decisions use the synchronised value `rxs`.
- States:
  - IDLE: on `rxs`=0 → START, bit counter cleared, baud counter cleared.
  - START: at baud count HALF-1, sample `rxs`. If 1 (glitch) → IDLE with no output. If 0 → DATA.
  - DATA: every CPB cycles, sample one bit, LSB first, into a shift register. After the 8th sample → STOP.
  - STOP: CPB cycles after the last data sample, sample the stop bit.
    - Stop bit 1: deliver the byte, then → IDLE.
    - Stop bit 0: pulse `frame_err`, discard the byte, then → WAIT_IDLE.
  - WAIT_IDLE: stay until `rxs`=1, then → IDLE. This stops a break condition from retriggering.
- Delivery:
  - If `valid`=0 or `ready`=1 in the delivery cycle: load `data` and set `valid` on the next edge.
  - Otherwise: keep the old `data`, pulse `overrun`, drop the new byte.
- Handshake: `valid` clears on the edge after `valid && ready`, unless a new byte is delivered in that same cycle; the new byte wins. `data` must not change while `valid` is high except through that simultaneous case.
- Baud counter width: $clog2(CPB). It reloads to 0 on every sample, so it never wraps.
- Asynchronous reset mid-frame aborts the frame immediately and returns all outputs to their reset values. No partial byte is ever delivered.

## Timing
- Falling edge of `rx` at cycle 0 → `rxs` low at cycle 2.
- Start sample at cycle 2+HALF = 28.
- Data bit k is sampled at 28 + (k+1)·CPB, for k = 0..7.
- Stop bit is sampled at 28 + 9·CPB = 496.
- `valid` rises at cycle 497. `frame_err` and `overrun` are high for exactly cycle 497.
- Back-to-back frames: IDLE is re-entered in the cycle after the stop sample, so a start edge arriving half a bit later is accepted.

## Configuration
- `UWU_RX_MAJORITY_EN` defined:
  - Each start, data and stop bit is a 2-of-3 majority of `rxs` at baud counts HALF-2, HALF-1 and HALF (and the equivalent offsets for later bits).
  - The decision is made at the third sample, so every sample point and the total latency shift by +1 cycle (`valid` at 498).
- Not defined: one sample at the points listed under Timing.

## Structure
- Shared package `uwu_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, STOP, WAIT_IDLE)
  - function `clks_per_bit(CLK_FREQ, BAUD)` returning the rounded divisor, reused by the transmitter
- Sub-module `uwu_sync`: parameterised N-flop synchroniser with reset value 1, also used for other async inputs.

## Test plan
- Send 0x55, then 0x72 ('r') at 115200 with `ready` held high → `data`=0x55 then 0x72, each with one `valid` cycle at cycle 497 of its frame; `frame_err`=`overrun`=0.
- Drive `rx` low for 10 cycles, then high → no `valid`; FSM back in IDLE by cycle 30.
- Send 0xA3 with the stop bit driven low → `frame_err` pulses once, `valid` stays 0. Hold `rx` low 1000 cycles then release, send 0x41 → `data`=0x41 valid.
- Send 0x11 then 0x22 with `ready`=0 → `data`=0x11 held, `overrun` pulses at the end of the second frame. Assert `ready` → `valid` drops the next cycle.
- Assert `rst_n`=0 after data bit 3 of 0xFF, release, send 0x0F → only 0x0F is delivered.
- Compile with `UWU_RX_MAJORITY_EN`, send 0x5A with one-cycle low glitches at each mid-bit → `data`=0x5A, `valid` at cycle 498.
